// File: rtl/aes_pkg.sv
// Shared definitions for the Rijndael ShiftRows pipeline: row offsets, byte
// placement helper, per-transaction control and skid occupancy encoding.
package aes_pkg;

    localparam int unsigned ROW_CNT    = 4;
    localparam int unsigned CTRL_TAG_W = 32;

    typedef struct packed {
        logic                  inv;
        logic [CTRL_TAG_W-1:0] tag;
    } ctrl_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Rotation amount Cr for row `row` of an NB-column state.
    function automatic int unsigned shift_offset(input int unsigned nb, input int unsigned row);
        int unsigned off;
        case (row)
            32'd0:   off = 32'd0;
            32'd1:   off = 32'd1;
            32'd2:   off = (nb == 32'd8) ? 32'd3 : 32'd2;
            default: off = (nb == 32'd8) ? 32'd4 : 32'd3;
        endcase
        return off;
    endfunction

    // LSB position of byte (row, col); byte k = 4*col + row sits MSB-first.
    function automatic int unsigned byte_lsb(input int unsigned nb, input int unsigned row,
                                             input int unsigned col);
        return 32 * nb - 8 - 8 * (ROW_CNT * col + row);
    endfunction

endpackage

// File: rtl/aes_shiftrows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for NB = 4, 6, 8.
module aes_shiftrows_perm
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic [32*NB-1:0] state,
    input  logic             inv,
    output logic [32*NB-1:0] perm_state_c
);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shiftrows_perm: NB must be 4, 6 or 8");
    end

    // Each destination byte picks one of two fixed source bytes.
    for (genvar r = 0; r < ROW_CNT; r++) begin : g_row
        localparam int unsigned OFF = shift_offset(NB, r);
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int unsigned FWD_COL = (c + OFF) % NB;
            localparam int unsigned INV_COL = (c + NB - OFF) % NB;
            localparam int unsigned DST_LSB = byte_lsb(NB, r, c);
            localparam int unsigned FWD_LSB = byte_lsb(NB, r, FWD_COL);
            localparam int unsigned INV_LSB = byte_lsb(NB, r, INV_COL);
            assign perm_state_c[DST_LSB +: 8] = inv ? state[INV_LSB +: 8] : state[FWD_LSB +: 8];
        end
    end

endmodule

// File: rtl/aes_shiftrows_pipe.sv
// Registered, valid/ready ShiftRows/InvShiftRows stage with sideband tag.
// Define AES_SHIFTROWS_SKID_EN for a second (skid) register and registered in_ready.
module aes_shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [32*NB-1:0]   in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_state,
    output logic [TAG_W-1:0]   out_tag,
    output logic [15:0]        blk_cnt
);

    localparam int unsigned STATE_W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (TAG_W < 1 || TAG_W > CTRL_TAG_W) begin : g_bad_tag
        $error("aes_shiftrows_pipe: TAG_W out of range");
    end

    ctrl_t              in_ctrl;
    logic [TAG_W-1:0]   in_tag_s;
    logic [STATE_W-1:0] perm_state_c;
    logic               out_xfer;

    assign in_ctrl  = '{inv: in_inv, tag: CTRL_TAG_W'(in_tag)};
    assign in_tag_s = in_ctrl.tag[TAG_W-1:0];
    assign out_xfer = out_valid && out_ready;

    if (TAG_W < CTRL_TAG_W) begin : g_tag_pad
        logic unused_tag_pad;
        assign unused_tag_pad = |in_ctrl.tag[CTRL_TAG_W-1:TAG_W];
    end

    aes_shiftrows_perm #(
        .NB (NB)
    ) u_perm (
        .state        (in_state),
        .inv          (in_ctrl.inv),
        .perm_state_c (perm_state_c)
    );

    // Output-side transfer counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (out_xfer) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end

`ifdef AES_SHIFTROWS_SKID_EN

    occ_e               occ;
    occ_e               occ_d;
    logic               load_out;
    logic               out_from_skid;
    logic               load_skid;
    logic [STATE_W-1:0] skid_state;
    logic [TAG_W-1:0]   skid_tag;

    // Occupancy: EMPTY, output register only, or output plus skid register.
    always_comb begin
        occ_d         = occ;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        case (occ)
            OCC_EMPTY: begin
                if (in_valid) begin
                    occ_d    = OCC_ONE;
                    load_out = 1'b1;
                end
            end
            OCC_ONE: begin
                case ({out_ready, in_valid})
                    2'b11:   load_out = 1'b1;
                    2'b10:   occ_d    = OCC_EMPTY;
                    2'b01: begin
                        occ_d     = OCC_TWO;
                        load_skid = 1'b1;
                    end
                    default: ;
                endcase
            end
            OCC_TWO: begin
                if (out_ready) begin
                    occ_d         = OCC_ONE;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ        <= OCC_EMPTY;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_state  <= '0;
            out_tag    <= '0;
            skid_state <= '0;
            skid_tag   <= '0;
        end else begin
            occ       <= occ_d;
            in_ready  <= (occ_d != OCC_TWO);
            out_valid <= (occ_d != OCC_EMPTY);
            if (load_out) begin
                out_state <= out_from_skid ? skid_state : perm_state_c;
                out_tag   <= out_from_skid ? skid_tag   : in_tag_s;
            end
            if (load_skid) begin
                skid_state <= perm_state_c;
                skid_tag   <= in_tag_s;
            end
        end
    end

`else

    // Single stage: refill whenever the register is empty or draining.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_state <= '0;
            out_tag   <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_state <= perm_state_c;
                out_tag   <= in_tag_s;
            end
        end
    end

`endif

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Directed bench for aes_shiftrows_pipe at NB = 4, 6, 8 (either skid build).
module tb_aes_shiftrows_pipe;

`ifdef AES_SHIFTROWS_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif
    localparam int NSTREAM = 70000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic v4 = 0, r4, inv4 = 0, ov4, ordy4 = 1;
    logic [3:0] tag4 = 0, ot4;
    logic [127:0] st4 = 0, os4;
    logic [15:0] cnt4;

    logic v6 = 0, r6, inv6 = 0, ov6, ordy6 = 1;
    logic [3:0] tag6 = 0, ot6;
    logic [191:0] st6 = 0, os6;
    logic [15:0] cnt6;

    logic v8 = 0, r8, inv8 = 0, ov8, ordy8 = 1;
    logic [3:0] tag8 = 0, ot8;
    logic [255:0] st8 = 0, os8;
    logic [15:0] cnt8;

    aes_shiftrows_pipe #(.NB(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_inv(inv4),
        .in_tag(tag4), .in_state(st4), .out_valid(ov4), .out_ready(ordy4),
        .out_state(os4), .out_tag(ot4), .blk_cnt(cnt4));
    aes_shiftrows_pipe #(.NB(6), .TAG_W(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6), .in_inv(inv6),
        .in_tag(tag6), .in_state(st6), .out_valid(ov6), .out_ready(ordy6),
        .out_state(os6), .out_tag(ot6), .blk_cnt(cnt6));
    aes_shiftrows_pipe #(.NB(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_inv(inv8),
        .in_tag(tag8), .in_state(st8), .out_valid(ov8), .out_ready(ordy8),
        .out_state(os8), .out_tag(ot8), .blk_cnt(cnt8));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
        return r;
    endfunction

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [191:0] SEQ6     = 192'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617;
    localparam logic [191:0] SEQ6_FWD = 192'h00050a0f_04090e13_080d1217_0c111603_10150207_1401060b;
    localparam logic [255:0] SEQ8     = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [255:0] SEQ8_FWD = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
    localparam logic [255:0] SEQ8_INV = 256'h001d1613_04011a17_08051e1b_0c09021f_100d0603_14110a07_18150e0b_1c19120f;

    initial begin
        logic [255:0] t, e;
        logic [127:0] x4, y4;
        logic [191:0] x6, y6;
        logic [255:0] x8, y8;
        logic [131:0] exp_q[$];
        int bad4, bad6, bad8, sent, rcvd, ndel, bad;

        // Reset
        tick(); tick();
        rst_n = 1'b1;
        check("rst_ov4", 256'(ov4), 0);
        check("rst_os4", 256'(os4), 0);
        check("rst_ot4", 256'(ot4), 0);
        check("rst_cnt4", 256'(cnt4), 0);
        check("rst_rdy4", 256'(r4), 1);
        check("rst_ov8", 256'(ov8), 0);

        // FIPS-197 round 1 forward, then inverse back
        v4 = 1; inv4 = 0; tag4 = 4'h5; st4 = FIPS_IN;
        tick();
        v4 = 0;
        check("fips_fwd_ov", 256'(ov4), 1);
        check("fips_fwd_state", 256'(os4), 256'(FIPS_OUT));
        check("fips_fwd_tag", 256'(ot4), 5);
        tick();
        check("fips_cnt1", 256'(cnt4), 1);
        check("fips_ov_drop", 256'(ov4), 0);
        v4 = 1; inv4 = 1; tag4 = 4'ha; st4 = FIPS_OUT;
        tick();
        v4 = 0;
        check("fips_inv_state", 256'(os4), 256'(FIPS_IN));
        check("fips_inv_tag", 256'(ot4), 4'ha);
        tick();

        // NB = 6 and NB = 8 directed vectors (byte k = k)
        v6 = 1; inv6 = 0; st6 = SEQ6; tag6 = 4'h6;
        v8 = 1; inv8 = 0; st8 = SEQ8; tag8 = 4'h8;
        tick();
        v6 = 0; v8 = 0;
        check("nb6_fwd", 256'(os6), 256'(SEQ6_FWD));
        check("nb6_tag", 256'(ot6), 6);
        check("nb8_fwd", os8, SEQ8_FWD);
        check("nb8_r2c0", 256'(os8[239:232]), 14);
        check("nb8_r3c0", 256'(os8[231:224]), 19);
        check("nb8_tag", 256'(ot8), 8);
        v8 = 1; inv8 = 1; st8 = SEQ8; tag8 = 4'h3;
        tick();
        v8 = 0;
        check("nb8_inv", os8, SEQ8_INV);
        tick();

        // Random forward-then-inverse round trips
        bad4 = 0; bad6 = 0; bad8 = 0;
        for (int i = 0; i < 1000; i++) begin
            t = rand256(); x4 = t[127:0];
            t = rand256(); x6 = t[191:0];
            x8 = rand256();
            v4 = 1; inv4 = 0; st4 = x4;
            v6 = 1; inv6 = 0; st6 = x6;
            v8 = 1; inv8 = 0; st8 = x8;
            tick();
            y4 = os4; y6 = os6; y8 = os8;
            inv4 = 1; st4 = y4;
            inv6 = 1; st6 = y6;
            inv8 = 1; st8 = y8;
            tick();
            if (!ov4 || os4 !== x4) bad4++;
            if (!ov6 || os6 !== x6) bad6++;
            if (!ov8 || os8 !== x8) bad8++;
        end
        v4 = 0; v6 = 0; v8 = 0; inv4 = 0;
        tick();
        check("roundtrip_nb4", 256'(bad4), 0);
        check("roundtrip_nb6", 256'(bad6), 0);
        check("roundtrip_nb8", 256'(bad8), 0);

        // Backpressure: 5 stalled cycles, then drain 6 blocks in order
        sent = 0; rcvd = 0;
        for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
            v4 = (sent < 6); inv4 = 0; tag4 = 4'(sent);
            st4 = {16{8'(8'h10 + sent)}};
            ordy4 = (cyc >= 5);
            #1;
            if (cyc < 5) check($sformatf("stall_rdy%0d", cyc), 256'(r4), 256'(cyc < 1 + SKID));
            if (cyc >= 1 && cyc < 5) check("stall_hold", 256'(os4), 256'({16{8'h10}}));
            if (ov4 && ordy4) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra", 1, 0);
                end else begin
                    e = 256'(exp_q.pop_front());
                    check("bp_order", 256'({ot4, os4}), e);
                end
                rcvd++;
            end
            if (v4 && r4) begin
                exp_q.push_back({4'(sent), st4});
                sent++;
            end
            tick();
        end
        v4 = 0; ordy4 = 1;
        check("bp_count", 256'(rcvd), 6);
        tick(); tick();
        check("bp_idle", 256'(ov4), 0);

        // Streaming with counter wrap
        rst_n = 0; tick(); rst_n = 1;
        ndel = 0; bad = 0;
        for (int i = 0; i <= NSTREAM; i++) begin
            v4 = (i < NSTREAM); st4 = {16{8'(i)}}; tag4 = 4'(i); ordy4 = 1;
            #1;
            if (i > 0 && !ov4) bad++;
            if (i < NSTREAM && !r4) bad++;
            if (ov4) begin
                if (os4 !== {16{8'(ndel)}} || ot4 !== 4'(ndel)) bad++;
                ndel++;
            end
            tick();
            if (cnt4 !== 16'(ndel)) bad++;
            if (ov4 && ndel == 65535) check("cnt_ffff", 256'(cnt4), 16'hffff);
            if (ndel == 65536 && ov4) check("cnt_wrap", 256'(cnt4), 0);
        end
        v4 = 0;
        check("stream_bad", 256'(bad), 0);
        check("stream_n", 256'(ndel), NSTREAM);
        check("cnt_final", 256'(cnt4), 256'(16'(NSTREAM)));
        tick();

        // Reset while holding blocks (skid full in the skid build)
        ordy4 = 0;
        for (int i = 0; i < 3; i++) begin
            v4 = 1; st4 = {16{8'hee}}; tag4 = 4'he;
            tick();
        end
        check("full_ov", 256'(ov4), 1);
        check("full_rdy", 256'(r4), 256'(SKID == 0 ? 0 : 0));
        v4 = 0; rst_n = 0;
        tick();
        rst_n = 1;
        check("mrst_ov", 256'(ov4), 0);
        check("mrst_cnt", 256'(cnt4), 0);
        check("mrst_rdy", 256'(r4), 1);
        ordy4 = 1; bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ov4) bad++;
        end
        check("mrst_no_stale", 256'(bad), 0);
        check("mrst_cnt_after", 256'(cnt4), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
